// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: 2*MW x 2*MW unsigned multiply done as four MW x MW partial
// products on one shared external multiplier, over four cycles.
//
// Build option: define MAC_EN to add an acc_clr input. When acc_clr=0 on an
// accepted start, the accumulator keeps its value, so the new product is
// added to the previous result (wraps silently at 4*MW bits).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; mul_a/mul_b driven to 0
// P0     | Al*Bl added unshifted
// P1     | Ah*Bl added shifted by MW
// P2     | Al*Bh added shifted by MW
// P3     | Ah*Bh added shifted by 2*MW
// DONE   | done pulse, prod valid; start here is accepted back-to-back

module mul16_seq_ctrl #(
   parameter int MW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2*MW-1:0]   A,
   input  logic [2*MW-1:0]   B,
`ifdef MAC_EN
   input  logic              acc_clr,
`endif
   output logic              busy,
   output logic              done,
   output logic [4*MW-1:0]   prod,
   output logic [MW-1:0]     mul_a,
   output logic [MW-1:0]     mul_b,
   input  logic [2*MW-1:0]   mul_p
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_P0   = 3'd1;
   localparam logic [2:0] S_P1   = 3'd2;
   localparam logic [2:0] S_P2   = 3'd3;
   localparam logic [2:0] S_P3   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [2*MW-1:0] a_q, a_d;
   logic [2*MW-1:0] b_q, b_d;
   logic [4*MW-1:0] acc_q, acc_d;
   logic [MW-1:0]   mul_a_q, mul_a_d;
   logic [MW-1:0]   mul_b_q, mul_b_d;
   logic [4*MW-1:0] p_ext;
   logic            clr_acc;

   assign p_ext = {{(2*MW){1'b0}}, mul_p};

`ifdef MAC_EN
   assign clr_acc = acc_clr;
`else
   assign clr_acc = 1'b1;
`endif

   // Sequencing, operand capture and accumulation of the current partial.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_P0;
               a_d     = A;
               b_d     = B;
               acc_d   = clr_acc ? '0 : acc_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_P0: begin
            acc_d   = acc_q + p_ext;
            state_d = S_P1;
         end
         S_P1: begin
            acc_d   = acc_q + (p_ext << MW);
            state_d = S_P2;
         end
         S_P2: begin
            acc_d   = acc_q + (p_ext << MW);
            state_d = S_P3;
         end
         S_P3: begin
            acc_d   = acc_q + (p_ext << (2*MW));
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Multiplier operands are decoded from the next state so they are
   // registered yet already valid in the first cycle of each P state.
   always_comb begin
      mul_a_d = '0;
      mul_b_d = '0;
      case (state_d)
         S_P0: begin mul_a_d = a_d[MW-1:0];    mul_b_d = b_d[MW-1:0];    end
         S_P1: begin mul_a_d = a_d[2*MW-1:MW]; mul_b_d = b_d[MW-1:0];    end
         S_P2: begin mul_a_d = a_d[MW-1:0];    mul_b_d = b_d[2*MW-1:MW]; end
         S_P3: begin mul_a_d = a_d[2*MW-1:MW]; mul_b_d = b_d[2*MW-1:MW]; end
         default: begin mul_a_d = '0;          mul_b_d = '0;             end
      endcase
   end

   // State, operand, accumulator and operand-byte registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign prod  = acc_q;
   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: expected products are queued with the cycle
// their done pulse is due and compared when the DUT reports done.
module tb_mul16_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        acc_clr;
   logic        busy;
   logic        done;
   logic [31:0] prod;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [31:0] model_acc = '0;

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;
   exp_t sb_q[$];

   mul16_seq_ctrl #(.MW(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
`ifdef MAC_EN
      .acc_clr(acc_clr),
`endif
      .busy   (busy),
      .done   (done),
      .prod   (prod),
      .mul_a  (mul_a),
      .mul_b  (mul_b),
      .mul_p  (mul_p)
   );

   assign mul_p = {8'b0, mul_a} * {8'b0, mul_b};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: result is due exactly in the cycle the bench scheduled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            check("done_pulse", {31'b0, done}, 32'd1);
            check("busy_at_done", {31'b0, busy}, 32'd1);
            check("prod", prod, sb_q[0].val);
            void'(sb_q.pop_front());
         end else if (done) begin
            check("spurious_done", {31'b0, done}, 32'd0);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_to(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   // Drive a request for the coming edge; product due 5 cycles later.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic clr);
      logic [31:0] p;
      exp_t e;
      p         = {16'b0, a} * {16'b0, b};
      model_acc = clr ? p : (model_acc + p);
      A         = a;
      B         = b;
      acc_clr   = clr;
      start     = 1'b1;
      e.val     = model_acc;
      e.due     = cyc + 5;
      sb_q.push_back(e);
   endtask

   task automatic step_release;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] ma [4];
      logic [7:0] mb [4];
      int k;
      ma = '{8'h34, 8'h12, 8'h34, 8'h12};
      mb = '{8'h78, 8'h78, 8'h56, 8'h56};

      rst_n   = 1'b0;
      start   = 1'b0;
      A       = '0;
      B       = '0;
      acc_clr = 1'b1;
      wait_cycles(2);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", {31'b0, busy}, 32'd0);
         check("idle_done", {31'b0, done}, 32'd0);
         check("idle_prod", prod, 32'd0);
         check("idle_mul_a", {24'b0, mul_a}, 32'd0);
         check("idle_mul_b", {24'b0, mul_b}, 32'd0);
         @(posedge clk);
         #1;
      end

      // Basic product with operand-byte sequence
      issue(16'h1234, 16'h5678, 1'b1);
      step_release();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("seq_mul_a", {24'b0, mul_a}, {24'b0, ma[i]});
         check("seq_mul_b", {24'b0, mul_b}, {24'b0, mb[i]});
         check("seq_busy", {31'b0, busy}, 32'd1);
      end
      wait_cycles(2);
      check("basic_hold", prod, 32'h06260060);

      // Max and zero operands
      issue(16'hFFFF, 16'hFFFF, 1'b1);
      step_release();
      wait_cycles(5);
      check("max_hold", prod, 32'hFFFE0001);
      issue(16'h0000, 16'hFFFF, 1'b1);
      step_release();
      wait_cycles(5);

      // Back-to-back with start held; operand changes after acceptance ignored
      k = cyc;
      issue(16'd3, 16'd5, 1'b1);
      wait_cycles(1);
      A = 16'd7;
      B = 16'd9;
      begin
         exp_t e;
         e.val     = 32'h3F;
         e.due     = k + 10;
         model_acc = 32'h3F;
         sb_q.push_back(e);
      end
      wait_to(k + 8);
      A = 16'hAAAA;
      B = 16'h5555;
      wait_to(k + 10);
      start = 1'b0;
      wait_cycles(2);
      check("b2b_hold", prod, 32'h3F);

      // Reset in P2 discards the in-flight result
      issue(16'hFFFF, 16'hFFFF, 1'b1);
      step_release();
      wait_cycles(2);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      model_acc = '0;
      #1;
      check("rst_prod", prod, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_mul_a", {24'b0, mul_a}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cycles(6);
      issue(16'd2, 16'd3, 1'b1);
      step_release();
      wait_cycles(5);

`ifdef MAC_EN
      issue(16'd3, 16'd5, 1'b1);
      step_release();
      wait_cycles(5);
      issue(16'd7, 16'd9, 1'b0);
      step_release();
      wait_cycles(5);
      check("mac_mid", prod, 32'h4E);
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      step_release();
      wait_cycles(5);
      check("mac_end", prod, 32'hFFFE004F);
`endif

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) wait_cycles(1);
      check("drain", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
